lo_source_gen: RTL

LO_SOURCE_GEN -- requirements
Module: lo_source_gen

---
 rtl/lo_source_gen.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lo_source_gen.sv
// LO source for a Gilbert mixer switching quad: selects an internally divided LO or a
// synchronised external differential LO, with a quiet gap on every source change.
module lo_source_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_lo_en,
    input  logic       ext_lo_p,
    input  logic       ext_lo_n,
    input  logic [2:0] int_lo_settings,
    output logic       lo_p,
    output logic       lo_n,
    output logic       lo_active,
    output logic       src_ext
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_INT  = 2'd2;
    localparam logic [1:0] ST_EXT  = 2'd3;

    localparam int SYNC_W = 6;

    // Settings bits are synchronised independently; a change that straddles an edge
    // can present a transient code, which the FSM treats like any other request change.
    logic [SYNC_W-1:0] sync_in;
    logic [SYNC_W-1:0] sync_s;

    assign sync_in = {int_lo_settings, ext_lo_n, ext_lo_p, ext_lo_en};

    generate
        for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sync_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_s[gi] = sync_reg;
        end
    endgenerate

    logic       ext_lo_en_s;
    logic       ext_lo_p_s;
    logic       ext_lo_n_s;
    logic [2:0] int_lo_settings_s;

    assign ext_lo_en_s       = sync_s[0];
    assign ext_lo_p_s        = sync_s[1];
    assign ext_lo_n_s        = sync_s[2];
    assign int_lo_settings_s = sync_s[5:3];

    function automatic logic [6:0] half_period(input logic [2:0] s);
        return 7'd1 << (s - 3'd1);
    endfunction

    logic [1:0] state_reg,     state_next;
    logic [1:0] gap_cnt_reg,   gap_cnt_next;
    logic [1:0] gap_req_reg,   gap_req_next;
    logic       phase_reg,     phase_next;
    logic [6:0] cnt_reg,       cnt_next;
    logic [2:0] s_lat_reg,     s_lat_next;
    logic [7:0] wd_reg,        wd_next;
    logic       ext_p_prev_reg;
    logic       lo_p_reg,      lo_p_next;
    logic       lo_n_reg,      lo_n_next;
    logic       lo_active_reg, lo_active_next;
    logic       src_ext_reg;

    logic [1:0] req_mode;
    logic       ext_p_edge;
    logic [7:0] wd_inc;
    logic       int_dead;

    always_comb begin
        if (ext_lo_en_s) begin
            req_mode = ST_EXT;
        end else if (int_lo_settings_s != 3'd0) begin
            req_mode = ST_INT;
        end else begin
            req_mode = ST_IDLE;
        end
    end

    assign ext_p_edge = ext_lo_p_s ^ ext_p_prev_reg;
    assign wd_inc     = (wd_reg == 8'hFF) ? 8'hFF : wd_reg + 8'd1;

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        gap_req_next = gap_req_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        s_lat_next   = s_lat_reg;
        wd_next      = wd_reg;

        case (state_reg)
            ST_GAP: begin
                if (req_mode != gap_req_reg) begin
                    gap_cnt_next = 2'd0;
                    gap_req_next = req_mode;
                end else if (gap_cnt_reg == 2'd3) begin
                    state_next   = req_mode;
                    gap_cnt_next = 2'd0;
                    if (req_mode == ST_INT) begin
                        phase_next = 1'b1;
                        s_lat_next = int_lo_settings_s;
                        cnt_next   = half_period(int_lo_settings_s) - 7'd1;
                    end
                    if (req_mode == ST_EXT) begin
                        wd_next = 8'd0;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 2'd1;
                end
            end

            ST_INT: begin
                if (req_mode != ST_INT) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = 2'd0;
                    gap_req_next = req_mode;
                    phase_next   = 1'b0;
                    cnt_next     = 7'd0;
                end else if (cnt_reg == 7'd0) begin
                    // Phase boundary: a new non-zero code takes effect here without a gap.
                    phase_next = ~phase_reg;
                    s_lat_next = int_lo_settings_s;
                    cnt_next   = half_period(int_lo_settings_s) - 7'd1;
                end else begin
                    cnt_next = cnt_reg - 7'd1;
                end
            end

            ST_EXT: begin
                if (req_mode != ST_EXT) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = 2'd0;
                    gap_req_next = req_mode;
                    wd_next      = 8'd0;
                end else if (ext_p_edge) begin
                    wd_next = 8'd0;
                end else begin
                    wd_next = wd_inc;
                end
            end

            default: begin
                if (req_mode != ST_IDLE) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = 2'd0;
                    gap_req_next = req_mode;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_comb begin
        lo_p_next      = 1'b0;
        lo_n_next      = 1'b0;
        lo_active_next = 1'b0;
        int_dead       = (s_lat_next != 3'd1) &&
                         (cnt_next == half_period(s_lat_next) - 7'd1);

        case (state_next)
            ST_INT: begin
                lo_active_next = 1'b1;
                lo_p_next      = phase_next & ~int_dead;
                lo_n_next      = ~phase_next & ~int_dead;
            end
            ST_EXT: begin
                if (wd_next != 8'hFF) begin
                    lo_active_next = 1'b1;
                    lo_p_next      = ext_lo_p_s & ~ext_lo_n_s;
                    lo_n_next      = ext_lo_n_s & ~ext_lo_p_s;
                end
            end
            default: begin
                lo_active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            gap_cnt_reg    <= 2'd0;
            gap_req_reg    <= ST_IDLE;
            phase_reg      <= 1'b0;
            cnt_reg        <= 7'd0;
            s_lat_reg      <= 3'd0;
            wd_reg         <= 8'd0;
            ext_p_prev_reg <= 1'b0;
            lo_p_reg       <= 1'b0;
            lo_n_reg       <= 1'b0;
            lo_active_reg  <= 1'b0;
            src_ext_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gap_cnt_reg    <= gap_cnt_next;
            gap_req_reg    <= gap_req_next;
            phase_reg      <= phase_next;
            cnt_reg        <= cnt_next;
            s_lat_reg      <= s_lat_next;
            wd_reg         <= wd_next;
            ext_p_prev_reg <= ext_lo_p_s;
            lo_p_reg       <= lo_p_next;
            lo_n_reg       <= lo_n_next;
            lo_active_reg  <= lo_active_next;
            src_ext_reg    <= (state_next == ST_EXT);
        end
    end

    assign lo_p      = lo_p_reg;
    assign lo_n      = lo_n_reg;
    assign lo_active = lo_active_reg;
    assign src_ext   = src_ext_reg;

endmodule
